// File: rtl/nes_input_controller.sv
// NES gamepad poller: periodically latches the pad, clocks out its eight
// serial button bits, and publishes both the raw active-high button vector
// and a priority-encoded 4-bit code for the grid controller.
module nes_input_controller #(
    parameter int HALF_BIT      = 300,
    parameter int POLL_INTERVAL = 833333
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [3:0] controller_out,
    output logic [7:0] buttons,
    output logic       frame_valid
);

    localparam int PHASE_W = $clog2(2 * HALF_BIT + 1);
    localparam int POLL_W  = $clog2(POLL_INTERVAL + 1);

    localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(2 * HALF_BIT - 1);
    localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_BIT - 1);
    localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_INTERVAL - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_HI,
        CLK_LO,
        DONE
    } state_t;

    state_t              state;
    logic [1:0]          sync;
    logic                data_s;
    logic [POLL_W-1:0]   poll;
    logic [PHASE_W-1:0]  phase;
    logic [2:0]          bit_idx;
    logic [7:0]          shreg;
    logic [7:0]          pressed;

    // Button priority: Start, Right, Left, Down, Up, A, B, Select.
    function automatic logic [3:0] encode(input logic [7:0] b);
        logic [3:0] code;
        if (b[3])      code = 4'b0100;
        else if (b[7]) code = 4'b1000;
        else if (b[6]) code = 4'b0111;
        else if (b[5]) code = 4'b0110;
        else if (b[4]) code = 4'b0101;
        else if (b[0]) code = 4'b0001;
        else if (b[1]) code = 4'b0010;
        else if (b[2]) code = 4'b0011;
        else           code = 4'b0000;
        return code;
    endfunction

    assign data_s = sync[1];

    // The final bit arrives on the same edge that publishes the frame, so it
    // is merged in directly rather than read back from the shift register.
    assign pressed = ~{data_s, shreg[6:0]};

    // Two-flop synchronizer for the pad's serial line; idles released (high).
    always_ff @(posedge clk) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], nes_data};
    end

    // Free-running frame-rate counter, independent of the FSM.
    always_ff @(posedge clk) begin
        if (reset)                 poll <= '0;
        else if (poll == POLL_LAST) poll <= '0;
        else                       poll <= poll + POLL_W'(1);
    end

    // Frame sequencer: latch pulse, seven shift clocks, then publish results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            phase          <= '0;
            bit_idx        <= '0;
            nes_latch      <= 1'b0;
            nes_clk        <= 1'b0;
            controller_out <= 4'b0000;
            buttons        <= 8'h00;
            frame_valid    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (poll == POLL_LAST) begin
                        state     <= LATCH;
                        nes_latch <= 1'b1;
                        phase     <= '0;
                    end
                end
                LATCH: begin
                    if (phase == LATCH_LAST) begin
                        shreg[0]  <= data_s;
                        bit_idx   <= 3'd1;
                        phase     <= '0;
                        nes_latch <= 1'b0;
                        nes_clk   <= 1'b1;
                        state     <= CLK_HI;
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                CLK_HI: begin
                    if (phase == HALF_LAST) begin
                        phase   <= '0;
                        nes_clk <= 1'b0;
                        state   <= CLK_LO;
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                CLK_LO: begin
                    if (phase == HALF_LAST) begin
                        phase          <= '0;
                        shreg[bit_idx] <= data_s;
                        if (bit_idx == 3'd7) begin
                            bit_idx        <= '0;
                            buttons        <= pressed;
                            controller_out <= encode(pressed);
                            frame_valid    <= 1'b1;
                            state          <= DONE;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            nes_clk <= 1'b1;
                            state   <= CLK_HI;
                        end
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
